// File: rtl/mipi_sched_pkg.sv
// Shared types and constants for the MIPI CSI-2 frame scheduler.
package mipi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LINE      = 3'd1,
    HBLANK    = 3'd2,
    WAIT_DONE = 3'd3,
    VBLANK    = 3'd4
  } sched_state_t;

  // Two 24-bit pixel channels per beat.
  localparam int BYTES_PER_BEAT = 6;

  function automatic logic [15:0] word_count_f(input logic [31:0] beats);
    logic [31:0] prod_s;
    prod_s = beats * 32'(BYTES_PER_BEAT);
    return prod_s[15:0];
  endfunction

endpackage

// File: rtl/mipi_sched_gap_timer.sv
// Blanking gap counter shared by horizontal and vertical blanking.
module mipi_sched_gap_timer #(
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [GAP_W-1:0] cnt_r;

  // Gap count: load on entry to a blanking state, count down while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (srst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec) begin
      cnt_r <= cnt_r - GAP_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A loaded value of 0 behaves like 1 so a zero gap still spends one cycle.
  assign expired = (cnt_r <= GAP_W'(1));

endmodule

// File: rtl/mipi_frame_scheduler.sv
// Frame sequencer between read_data_mux and the CSI-2 TX: gates the stream,
// marks frame start / line end, inserts blanking and waits for csi_done.
module mipi_frame_scheduler
  import mipi_sched_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int BEATS_W = 12,
  parameter int LINES_W = 12,
  parameter int GAP_W   = 16,
  parameter int TMO_W   = 20
) (
  input  logic               dphy_clk_200M,
  input  logic               rst_n_200mhz,
  input  logic [BEATS_W-1:0] cfg_line_beats,
  input  logic [LINES_W-1:0] cfg_lines,
  input  logic [GAP_W-1:0]   cfg_hblank,
  input  logic [GAP_W-1:0]   cfg_vblank,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               frame_start_req,
  input  logic               read_frame_reset,
  input  logic [DATA_W-1:0]  s_axis_tdata_a,
  input  logic [DATA_W-1:0]  s_axis_tdata_b,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [DATA_W-1:0]  m_axis_tdata_a,
  output logic [DATA_W-1:0]  m_axis_tdata_b,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic [15:0]        csi2_word_count,
  input  logic               csi_done,
  output logic               busy,
  output logic               frame_done,
  output logic               err_cfg,
  output logic               err_timeout
);

  sched_state_t       state_r, state_nx_s;
  logic [BEATS_W-1:0] beats_r, beat_r;
  logic [LINES_W-1:0] lines_r, line_r;
  logic [GAP_W-1:0]   hblank_r, vblank_r, gap_val_s;
  logic [TMO_W-1:0]   timeout_r, tmo_r;
  logic [15:0]        word_count_r;
  logic               sof_r, frame_done_r, err_cfg_r, err_timeout_r;
  logic               in_line_s, xfer_s, last_beat_s;
  logic               latch_s, accept_s, cfg_err_s, tmo_err_s, done_s;
  logic               gap_load_s, gap_dec_s, gap_expired_s;

  // The abort also masks the stream in the cycle it is asserted.
  assign in_line_s      = (state_r == LINE) && !read_frame_reset;
  assign m_axis_tvalid  = s_axis_tvalid & in_line_s;
  assign s_axis_tready  = m_axis_tready & in_line_s;
  assign m_axis_tdata_a = s_axis_tdata_a;
  assign m_axis_tdata_b = s_axis_tdata_b;
  assign xfer_s         = m_axis_tvalid & m_axis_tready;
  assign last_beat_s    = (beat_r == beats_r - BEATS_W'(1));
  assign m_axis_tlast   = in_line_s & last_beat_s;
  assign m_axis_tuser   = in_line_s & sof_r;

  assign busy            = (state_r != IDLE);
  assign frame_done      = frame_done_r;
  assign err_cfg         = err_cfg_r;
  assign err_timeout     = err_timeout_r;
  assign csi2_word_count = word_count_r;

  mipi_sched_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk      (dphy_clk_200M),
    .rst_n    (rst_n_200mhz),
    .srst     (read_frame_reset),
    .load     (gap_load_s),
    .load_val (gap_val_s),
    .dec      (gap_dec_s),
    .expired  (gap_expired_s)
  );

  // State register.
  always_ff @(posedge dphy_clk_200M or negedge rst_n_200mhz) begin
    if (!rst_n_200mhz) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and one-cycle control strobes.
  always_comb begin
    state_nx_s = state_r;
    latch_s    = 1'b0;
    accept_s   = 1'b0;
    cfg_err_s  = 1'b0;
    tmo_err_s  = 1'b0;
    done_s     = 1'b0;
    gap_load_s = 1'b0;
    gap_dec_s  = 1'b0;
    gap_val_s  = '0;
    if (read_frame_reset) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_start_req) begin
            latch_s = 1'b1;
            if (cfg_line_beats == '0 || cfg_lines == '0) begin
              cfg_err_s = 1'b1;
            end else begin
              accept_s   = 1'b1;
              state_nx_s = LINE;
            end
          end else begin
            state_nx_s = IDLE;
          end
        end
        LINE: begin
          if (xfer_s && last_beat_s) begin
            if (line_r == lines_r - LINES_W'(1)) begin
              state_nx_s = WAIT_DONE;
            end else if (hblank_r == '0) begin
              state_nx_s = LINE;
            end else begin
              state_nx_s = HBLANK;
              gap_load_s = 1'b1;
              gap_val_s  = hblank_r;
            end
          end else begin
            state_nx_s = LINE;
          end
        end
        HBLANK: begin
          if (gap_expired_s) begin
            state_nx_s = LINE;
          end else begin
            gap_dec_s = 1'b1;
          end
        end
        WAIT_DONE: begin
          if (csi_done) begin
            state_nx_s = VBLANK;
            gap_load_s = 1'b1;
            gap_val_s  = vblank_r;
          end else if (timeout_r != '0 && tmo_r == timeout_r - TMO_W'(1)) begin
            state_nx_s = IDLE;
            tmo_err_s  = 1'b1;
          end else begin
            state_nx_s = WAIT_DONE;
          end
        end
        VBLANK: begin
          if (gap_expired_s) begin
            state_nx_s = IDLE;
            done_s     = 1'b1;
          end else begin
            gap_dec_s = 1'b1;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // Shadow config, beat/line/timeout counters and registered status pulses.
  always_ff @(posedge dphy_clk_200M or negedge rst_n_200mhz) begin
    if (!rst_n_200mhz) begin
      beats_r       <= '0;
      lines_r       <= '0;
      hblank_r      <= '0;
      vblank_r      <= '0;
      timeout_r     <= '0;
      beat_r        <= '0;
      line_r        <= '0;
      tmo_r         <= '0;
      sof_r         <= 1'b0;
      word_count_r  <= 16'd0;
      frame_done_r  <= 1'b0;
      err_cfg_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else if (read_frame_reset) begin
      beat_r        <= '0;
      line_r        <= '0;
      tmo_r         <= '0;
      sof_r         <= 1'b0;
      frame_done_r  <= 1'b0;
      err_cfg_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      frame_done_r  <= done_s;
      err_cfg_r     <= cfg_err_s;
      err_timeout_r <= tmo_err_s;
      if (latch_s) begin
        beats_r   <= cfg_line_beats;
        lines_r   <= cfg_lines;
        hblank_r  <= cfg_hblank;
        vblank_r  <= cfg_vblank;
        timeout_r <= cfg_timeout;
      end
      if (accept_s) begin
        word_count_r <= word_count_f(32'(cfg_line_beats));
        beat_r       <= '0;
        line_r       <= '0;
        sof_r        <= 1'b1;
      end else if (xfer_s) begin
        sof_r <= 1'b0;
        if (last_beat_s) begin
          beat_r <= '0;
          line_r <= line_r + LINES_W'(1);
        end else begin
          beat_r <= beat_r + BEATS_W'(1);
        end
      end
      tmo_r <= (state_r == WAIT_DONE) ? tmo_r + TMO_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_mipi_frame_scheduler.sv
// Randomized self-checking bench: observed stream and status are checked
// against frame-level arithmetic derived from the latched configuration.
module tb_mipi_frame_scheduler;

  localparam int DATA_W  = 24;
  localparam int BEATS_W = 12;
  localparam int LINES_W = 12;
  localparam int GAP_W   = 16;
  localparam int TMO_W   = 20;

  logic               clk, rst_n;
  logic [BEATS_W-1:0] cfg_line_beats;
  logic [LINES_W-1:0] cfg_lines;
  logic [GAP_W-1:0]   cfg_hblank, cfg_vblank;
  logic [TMO_W-1:0]   cfg_timeout;
  logic               frame_start_req, read_frame_reset;
  logic [DATA_W-1:0]  s_axis_tdata_a, s_axis_tdata_b, m_axis_tdata_a, m_axis_tdata_b;
  logic               s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
  logic               m_axis_tlast, m_axis_tuser;
  logic [15:0]        csi2_word_count;
  logic               csi_done, busy, frame_done, err_cfg, err_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  mipi_frame_scheduler #(
    .DATA_W(DATA_W), .BEATS_W(BEATS_W), .LINES_W(LINES_W), .GAP_W(GAP_W), .TMO_W(TMO_W)
  ) dut (
    .dphy_clk_200M    (clk),
    .rst_n_200mhz     (rst_n),
    .cfg_line_beats   (cfg_line_beats),
    .cfg_lines        (cfg_lines),
    .cfg_hblank       (cfg_hblank),
    .cfg_vblank       (cfg_vblank),
    .cfg_timeout      (cfg_timeout),
    .frame_start_req  (frame_start_req),
    .read_frame_reset (read_frame_reset),
    .s_axis_tdata_a   (s_axis_tdata_a),
    .s_axis_tdata_b   (s_axis_tdata_b),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata_a   (m_axis_tdata_a),
    .m_axis_tdata_b   (m_axis_tdata_b),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .csi2_word_count  (csi2_word_count),
    .csi_done         (csi_done),
    .busy             (busy),
    .frame_done       (frame_done),
    .err_cfg          (err_cfg),
    .err_timeout      (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic scramble_cfg();
    cfg_line_beats = BEATS_W'($urandom_range(1, 7));
    cfg_lines      = LINES_W'($urandom_range(1, 5));
    cfg_hblank     = GAP_W'($urandom_range(0, 9));
    cfg_vblank     = GAP_W'($urandom_range(0, 9));
    cfg_timeout    = TMO_W'($urandom_range(1, 3));
  endtask

  // One frame: b beats x l lines, gaps h/v, tready mode 0=always 1=toggle 2=random.
  task automatic run_frame(input int b, input int l, input int h, input int v,
                           input int mode, input int tmo, input bit withhold);
    int k, lim, last_cyc, csi_cyc, d;
    bit waiting, saw_done;
    cfg_line_beats  = BEATS_W'(b);
    cfg_lines       = LINES_W'(l);
    cfg_hblank      = GAP_W'(h);
    cfg_vblank      = GAP_W'(v);
    cfg_timeout     = TMO_W'(tmo);
    frame_start_req = 1'b1;
    s_axis_tvalid   = 1'b1;
    @(negedge clk);
    chk("req_idle", 32'(busy), 32'd0);
    adv();
    frame_start_req = 1'b0;
    scramble_cfg();
    k = 0; lim = 0; last_cyc = cyc; waiting = 1'b0;
    while (k < b * l && lim < 3000) begin
      s_axis_tdata_a  = DATA_W'($urandom);
      s_axis_tdata_b  = DATA_W'($urandom);
      m_axis_tready   = (mode == 0) ? 1'b1 : (mode == 1) ? ((lim % 2) == 0) : 1'($urandom_range(0, 1));
      frame_start_req = ($urandom_range(0, 9) == 0);
      csi_done        = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      if (lim == 0) begin
        chk("busy_start", 32'(busy), 32'd1);
        chk("word_count", 32'(csi2_word_count), 32'((b * 6) & 16'hFFFF));
      end
      if (m_axis_tvalid && waiting) begin
        chk("hblank_gap", 32'(cyc - last_cyc - 1), 32'(h));
        waiting = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("tuser", 32'(m_axis_tuser), 32'(k == 0));
        chk("tlast", 32'(m_axis_tlast), 32'((k % b) == b - 1));
        chk("tdata_a", 32'(m_axis_tdata_a), 32'(s_axis_tdata_a));
        chk("tdata_b", 32'(m_axis_tdata_b), 32'(s_axis_tdata_b));
        if ((k % b) == b - 1) begin
          last_cyc = cyc;
          waiting  = (k != b * l - 1);
        end
        k++;
      end
      adv();
      lim++;
    end
    frame_start_req = 1'b0;
    csi_done        = 1'b0;
    if (lim >= 3000) chk("xfer_budget", 32'(k), 32'(b * l));
    if (withhold) begin
      saw_done = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (frame_done) saw_done = 1'b1;
        if (err_timeout) break;
        adv();
      end
      chk("tmo_latency", 32'(cyc - last_cyc), 32'(tmo + 1));
      chk("tmo_idle", 32'(busy), 32'd0);
      chk("tmo_no_done", 32'(saw_done), 32'd0);
      adv();
      @(negedge clk);
      chk("tmo_one_pulse", 32'(err_timeout), 32'd0);
      adv();
    end else begin
      d = $urandom_range(0, 4);
      for (int i = 0; i < d; i++) begin
        frame_start_req = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_no_valid", 32'(m_axis_tvalid), 32'd0);
        adv();
      end
      frame_start_req = 1'b0;
      csi_done        = 1'b1;
      @(negedge clk);
      csi_cyc = cyc;
      adv();
      csi_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (frame_done) break;
        adv();
      end
      chk("done_latency", 32'(cyc - csi_cyc), 32'(((v == 0) ? 1 : v) + 1));
      chk("done_idle", 32'(busy), 32'd0);
      adv();
      @(negedge clk);
      chk("done_one_pulse", 32'(frame_done), 32'd0);
      chk("req_not_queued", 32'(busy), 32'd0);
      adv();
    end
  endtask

  task automatic cfg_err(input int b, input int l);
    cfg_line_beats  = BEATS_W'(b);
    cfg_lines       = LINES_W'(l);
    frame_start_req = 1'b1;
    adv();
    frame_start_req = 1'b0;
    @(negedge clk);
    chk("err_cfg_pulse", 32'(err_cfg), 32'd1);
    chk("err_cfg_idle", 32'(busy), 32'd0);
    chk("err_cfg_novalid", 32'(m_axis_tvalid), 32'd0);
    adv();
    @(negedge clk);
    chk("err_cfg_one", 32'(err_cfg), 32'd0);
    adv();
  endtask

  task automatic abort_test();
    int k, lim;
    cfg_line_beats  = BEATS_W'(4);
    cfg_lines       = LINES_W'(2);
    cfg_hblank      = GAP_W'(3);
    cfg_vblank      = GAP_W'(2);
    cfg_timeout     = TMO_W'(0);
    m_axis_tready   = 1'b1;
    frame_start_req = 1'b1;
    adv();
    frame_start_req = 1'b0;
    k = 0; lim = 0;
    while (k < 5 && lim < 200) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) k++;
      adv();
      lim++;
    end
    chk("abort_reach_line1", 32'(k), 32'd5);
    read_frame_reset = 1'b1;
    @(negedge clk);
    chk("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("abort_tready", 32'(s_axis_tready), 32'd0);
    adv();
    read_frame_reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(frame_done), 32'd0);
    chk("abort_no_err", 32'(err_timeout | err_cfg), 32'd0);
    adv();
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_line_beats = '0; cfg_lines = '0; cfg_hblank = '0; cfg_vblank = '0; cfg_timeout = '0;
    frame_start_req = 1'b0; read_frame_reset = 1'b0; csi_done = 1'b0;
    s_axis_tdata_a = '0; s_axis_tdata_b = '0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_cfg", 32'(err_cfg), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_word_count", 32'(csi2_word_count), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_tlast_tuser", 32'(m_axis_tlast | m_axis_tuser), 32'd0);
    rst_n = 1'b1;
    adv();

    run_frame(4, 2, 3, 2, 0, 0, 1'b0);
    run_frame(4, 2, 3, 2, 1, 0, 1'b0);
    cfg_err(0, 3);
    cfg_err(5, 0);
    run_frame(1, 1, 0, 0, 2, 0, 1'b0);
    run_frame(3, 2, 1, 1, 0, 100, 1'b1);
    abort_test();
    run_frame(4, 2, 3, 2, 2, 0, 1'b0);
    run_frame(5, 3, 2, 4, 2, 0, 1'b0);
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 4),
                $urandom_range(0, 3), $urandom_range(0, 2), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
